bus_arbiter: RTL and testbench

//  Two-master arbiter for the shared memory-mapped bus: DataMemory (0x0000_0000..), BCD (0x4000_0010), UART (0x4000_0018..0x4000_0020).

---
 rtl/bus_arbiter_if.sv | 45 ++++
 rtl/bus_arbiter.sv | 129 ++++++++++++
 tb/tb_bus_arbiter.sv | 277 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/bus_arbiter_if.sv
// Signal bundle between the two bus masters, the arbiter and the shared memory-mapped bus.
// The arbiter takes the slave view; the master view is used by whatever drives the requests.
interface bus_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              m0_req;
  logic              m0_we;
  logic [ADDR_W-1:0] m0_addr;
  logic [DATA_W-1:0] m0_wdata;
  logic [DATA_W-1:0] m0_rdata;
  logic              m0_ack;
  logic              m0_stall;

  logic              m1_req;
  logic              m1_we;
  logic [ADDR_W-1:0] m1_addr;
  logic [DATA_W-1:0] m1_wdata;
  logic [DATA_W-1:0] m1_rdata;
  logic              m1_ack;

  logic              MemRead;
  logic              MemWrite;
  logic [ADDR_W-1:0] Address;
  logic [DATA_W-1:0] Write_data;
  logic [DATA_W-1:0] Read_data;

  modport slave (
    input  m0_req, m0_we, m0_addr, m0_wdata,
    output m0_rdata, m0_ack, m0_stall,
    input  m1_req, m1_we, m1_addr, m1_wdata,
    output m1_rdata, m1_ack,
    output MemRead, MemWrite, Address, Write_data,
    input  Read_data
  );

  modport master (
    output m0_req, m0_we, m0_addr, m0_wdata,
    input  m0_rdata, m0_ack, m0_stall,
    output m1_req, m1_we, m1_addr, m1_wdata,
    input  m1_rdata, m1_ack,
    input  MemRead, MemWrite, Address, Write_data,
    output Read_data
  );
endinterface

// File: rtl/bus_arbiter.sv
// Two-master arbiter for the shared bus: one registered single-cycle access at a time,
// read data captured at the end of the access and returned with a one-cycle ack.
module bus_arbiter #(
  parameter int          ADDR_W     = 32,
  parameter int          DATA_W     = 32,
  parameter int unsigned FIXED_PRIO = 0
) (
  input logic         clk,
  input logic         reset,
  bus_arbiter_if.slave bus
);

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } state_t;

  state_t            state_q, state_d;
  logic              cur_q, cur_d;
  logic              last_q, last_d;
  logic              mem_read_q, mem_read_d;
  logic              mem_write_q, mem_write_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] m0_rdata_q, m0_rdata_d;
  logic [DATA_W-1:0] m1_rdata_q, m1_rdata_d;
  logic              m0_ack_q, m0_ack_d;
  logic              m1_ack_q, m1_ack_d;

  logic              elig0, elig1;
  logic              winner;
  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;

  // The master occupying the bus this cycle is also excluded: its ack only appears
  // next cycle, so a held request would otherwise be issued twice.
  always_comb begin
    elig0 = bus.m0_req & ~m0_ack_q & ~((state_q == ACCESS) & (cur_q == 1'b0));
    elig1 = bus.m1_req & ~m1_ack_q & ~((state_q == ACCESS) & (cur_q == 1'b1));

    winner = 1'b0;
    if (elig0 && elig1) begin
      winner = (FIXED_PRIO != 0) ? 1'b0 : ~last_q;
    end else if (elig1) begin
      winner = 1'b1;
    end

    sel_we    = winner ? bus.m1_we    : bus.m0_we;
    sel_addr  = winner ? bus.m1_addr  : bus.m0_addr;
    sel_wdata = winner ? bus.m1_wdata : bus.m0_wdata;
  end

  always_comb begin
    state_d     = IDLE;
    cur_d       = cur_q;
    last_d      = last_q;
    mem_read_d  = 1'b0;
    mem_write_d = 1'b0;
    addr_d      = '0;
    wdata_d     = '0;

    if (elig0 || elig1) begin
      state_d     = ACCESS;
      cur_d       = winner;
      last_d      = winner;
      mem_read_d  = ~sel_we;
      mem_write_d = sel_we;
      addr_d      = sel_addr;
      wdata_d     = sel_wdata;
    end
  end

  always_comb begin
    m0_ack_d   = 1'b0;
    m1_ack_d   = 1'b0;
    m0_rdata_d = m0_rdata_q;
    m1_rdata_d = m1_rdata_q;

    if (state_q == ACCESS) begin
      if (cur_q) begin
        m1_ack_d   = 1'b1;
        m1_rdata_d = bus.Read_data;
      end else begin
        m0_ack_d   = 1'b1;
        m0_rdata_d = bus.Read_data;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      cur_q       <= 1'b0;
      last_q      <= 1'b1;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      m0_rdata_q  <= '0;
      m1_rdata_q  <= '0;
      m0_ack_q    <= 1'b0;
      m1_ack_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      cur_q       <= cur_d;
      last_q      <= last_d;
      mem_read_q  <= mem_read_d;
      mem_write_q <= mem_write_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      m0_rdata_q  <= m0_rdata_d;
      m1_rdata_q  <= m1_rdata_d;
      m0_ack_q    <= m0_ack_d;
      m1_ack_q    <= m1_ack_d;
    end
  end

  assign bus.MemRead    = mem_read_q;
  assign bus.MemWrite   = mem_write_q;
  assign bus.Address    = addr_q;
  assign bus.Write_data = wdata_q;
  assign bus.m0_rdata   = m0_rdata_q;
  assign bus.m1_rdata   = m1_rdata_q;
  assign bus.m0_ack     = m0_ack_q;
  assign bus.m1_ack     = m1_ack_q;
  assign bus.m0_stall   = bus.m0_req & ~m0_ack_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed bench for bus_arbiter: one round-robin instance and one fixed-priority instance
// sharing clock and reset, each with a simple combinational bus read model.
module tb_bus_arbiter;

  logic clk;
  logic reset;
  int   n_tests;
  int   n_fail;

  bus_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bif0 ();
  bus_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bif1 ();

  bus_arbiter #(.ADDR_W(32), .DATA_W(32), .FIXED_PRIO(0)) dut_rr (
    .clk  (clk),
    .reset(reset),
    .bus  (bif0)
  );

  bus_arbiter #(.ADDR_W(32), .DATA_W(32), .FIXED_PRIO(1)) dut_fp (
    .clk  (clk),
    .reset(reset),
    .bus  (bif1)
  );

  function automatic logic [31:0] rd_model(input logic [31:0] a);
    if (a == 32'h0000_0004) return 32'hDEAD_BEEF;
    return a ^ 32'hA5A5_5A5A;
  endfunction

  function automatic int grant_of(input logic rd, input logic wr, input logic [31:0] a);
    if (!(rd || wr)) return -1;
    if (a == 32'h0000_0010) return 0;
    if (a == 32'h0000_0020) return 1;
    return 9;
  endfunction

  assign bif0.Read_data = rd_model(bif0.Address);
  assign bif1.Read_data = rd_model(bif1.Address);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    n_tests++;
    if (bif0.MemRead !== 1'b0 || bif0.MemWrite !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_bus_ctl: got rd=%b wr=%b expected 0 0", bif0.MemRead, bif0.MemWrite);
    end
    n_tests++;
    if (bif0.Address !== 32'h0 || bif0.Write_data !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_bus_data: got addr=%h wdata=%h expected 0 0", bif0.Address, bif0.Write_data);
    end
    n_tests++;
    if (bif0.m0_ack !== 1'b0 || bif0.m1_ack !== 1'b0 || bif1.m0_ack !== 1'b0 || bif1.m1_ack !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_ack: got %b%b%b%b expected 0000", bif0.m0_ack, bif0.m1_ack, bif1.m0_ack, bif1.m1_ack);
    end
    n_tests++;
    if (bif0.m0_rdata !== 32'h0 || bif0.m1_rdata !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_rdata: got %h %h expected 0 0", bif0.m0_rdata, bif0.m1_rdata);
    end
    @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic test_read();
    tick();
    bif0.m0_req  = 1'b1;
    bif0.m0_we   = 1'b0;
    bif0.m0_addr = 32'h0000_0004;
    @(negedge clk);
    n_tests++;
    if (bif0.m0_stall !== 1'b1 || bif0.MemRead !== 1'b0) begin
      n_fail++;
      $display("FAIL read_t0: got stall=%b rd=%b expected 1 0", bif0.m0_stall, bif0.MemRead);
    end
    tick();
    @(negedge clk);
    n_tests++;
    if (bif0.MemRead !== 1'b1 || bif0.Address !== 32'h0000_0004 || bif0.m0_stall !== 1'b1 || bif0.m0_ack !== 1'b0) begin
      n_fail++;
      $display("FAIL read_t1: got rd=%b addr=%h stall=%b ack=%b expected 1 00000004 1 0",
               bif0.MemRead, bif0.Address, bif0.m0_stall, bif0.m0_ack);
    end
    tick();
    @(negedge clk);
    n_tests++;
    if (bif0.m0_ack !== 1'b1 || bif0.m0_rdata !== 32'hDEAD_BEEF || bif0.m0_stall !== 1'b0 || bif0.MemRead !== 1'b0) begin
      n_fail++;
      $display("FAIL read_t2: got ack=%b rdata=%h stall=%b rd=%b expected 1 deadbeef 0 0",
               bif0.m0_ack, bif0.m0_rdata, bif0.m0_stall, bif0.MemRead);
    end
    bif0.m0_req = 1'b0;
    tick();
    @(negedge clk);
    n_tests++;
    if (bif0.m0_ack !== 1'b0 || bif0.m0_rdata !== 32'hDEAD_BEEF) begin
      n_fail++;
      $display("FAIL read_t3: got ack=%b rdata=%h expected 0 deadbeef", bif0.m0_ack, bif0.m0_rdata);
    end
  endtask

  task automatic test_reset_mid();
    int acks;
    tick();
    bif0.m0_req   = 1'b1;
    bif0.m0_we    = 1'b1;
    bif0.m0_addr  = 32'h0000_0100;
    bif0.m0_wdata = 32'h0000_0055;
    tick();
    @(negedge clk);
    n_tests++;
    if (bif0.MemWrite !== 1'b1) begin
      n_fail++;
      $display("FAIL rstmid_pre: got wr=%b expected 1", bif0.MemWrite);
    end
    #1 reset = 1'b1;
    #1;
    n_tests++;
    if (bif0.MemWrite !== 1'b0 || bif0.Address !== 32'h0 || bif0.m0_ack !== 1'b0 || bif0.m0_rdata !== 32'h0) begin
      n_fail++;
      $display("FAIL rstmid_async: got wr=%b addr=%h ack=%b rdata=%h expected 0 0 0 0",
               bif0.MemWrite, bif0.Address, bif0.m0_ack, bif0.m0_rdata);
    end
    bif0.m0_req = 1'b0;
    bif0.m0_we  = 1'b0;
    tick();
    reset = 1'b0;
    acks = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (bif0.m0_ack === 1'b1 || bif0.m1_ack === 1'b1) acks++;
    end
    n_tests++;
    if (acks !== 0) begin
      n_fail++;
      $display("FAIL rstmid_noack: got %0d ack cycles expected 0", acks);
    end
  endtask

  // Both masters issue two reads each, re-requesting in their ack cycle.
  task automatic test_round_robin();
    int exp_g[8]  = '{-1, 0, 1, -1, 0, 1, -1, -1};
    int exp_a0[8] = '{0, 0, 1, 0, 0, 1, 0, 0};
    int exp_a1[8] = '{0, 0, 0, 1, 0, 0, 1, 0};
    int rem0;
    int rem1;
    int g;
    rem0 = 2;
    rem1 = 2;
    tick();
    bif0.m0_req  = 1'b1;
    bif0.m0_we   = 1'b0;
    bif0.m0_addr = 32'h0000_0010;
    bif0.m1_req  = 1'b1;
    bif0.m1_we   = 1'b0;
    bif0.m1_addr = 32'h0000_0020;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      g = grant_of(bif0.MemRead, bif0.MemWrite, bif0.Address);
      n_tests++;
      if (g !== exp_g[c] || int'(bif0.m0_ack) !== exp_a0[c] || int'(bif0.m1_ack) !== exp_a1[c]) begin
        n_fail++;
        $display("FAIL rr_cycle%0d: got grant=%0d ack0=%b ack1=%b expected %0d %0d %0d",
                 c, g, bif0.m0_ack, bif0.m1_ack, exp_g[c], exp_a0[c], exp_a1[c]);
      end
      if (bif0.m0_ack === 1'b1) begin
        rem0--;
        if (rem0 == 0) bif0.m0_req = 1'b0;
      end
      if (bif0.m1_ack === 1'b1) begin
        rem1--;
        if (rem1 == 0) bif0.m1_req = 1'b0;
      end
    end
    n_tests++;
    if (bif0.m0_rdata !== 32'hA5A5_5A4A || bif0.m1_rdata !== 32'hA5A5_5A7A) begin
      n_fail++;
      $display("FAIL rr_rdata: got %h %h expected a5a55a4a a5a55a7a", bif0.m0_rdata, bif0.m1_rdata);
    end
  endtask

  // Both masters keep a request up continuously; m0 wins the only tie.
  task automatic test_fixed_prio();
    int g;
    int eg;
    int ea0;
    int ea1;
    tick();
    bif1.m0_req  = 1'b1;
    bif1.m0_we   = 1'b0;
    bif1.m0_addr = 32'h0000_0010;
    bif1.m1_req  = 1'b1;
    bif1.m1_we   = 1'b0;
    bif1.m1_addr = 32'h0000_0020;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      eg  = (c % 3 == 1) ? 0 : ((c % 3 == 2) ? 1 : -1);
      ea0 = (c % 3 == 2) ? 1 : 0;
      ea1 = (c >= 3 && c % 3 == 0) ? 1 : 0;
      g = grant_of(bif1.MemRead, bif1.MemWrite, bif1.Address);
      n_tests++;
      if (g !== eg || int'(bif1.m0_ack) !== ea0 || int'(bif1.m1_ack) !== ea1) begin
        n_fail++;
        $display("FAIL fp_cycle%0d: got grant=%0d ack0=%b ack1=%b expected %0d %0d %0d",
                 c, g, bif1.m0_ack, bif1.m1_ack, eg, ea0, ea1);
      end
    end
    bif1.m0_req = 1'b0;
    bif1.m1_req = 1'b0;
    tick();
    tick();
  endtask

  task automatic test_write();
    tick();
    bif0.m1_req   = 1'b1;
    bif0.m1_we    = 1'b1;
    bif0.m1_addr  = 32'h4000_0010;
    bif0.m1_wdata = 32'h0000_01FF;
    tick();
    @(negedge clk);
    n_tests++;
    if (bif0.MemWrite !== 1'b1 || bif0.MemRead !== 1'b0 || bif0.Address !== 32'h4000_0010 ||
        bif0.Write_data !== 32'h0000_01FF || bif0.m1_ack !== 1'b0) begin
      n_fail++;
      $display("FAIL wr_access: got wr=%b rd=%b addr=%h wdata=%h ack=%b expected 1 0 40000010 000001ff 0",
               bif0.MemWrite, bif0.MemRead, bif0.Address, bif0.Write_data, bif0.m1_ack);
    end
    tick();
    @(negedge clk);
    n_tests++;
    if (bif0.m1_ack !== 1'b1 || bif0.MemWrite !== 1'b0 || bif0.m0_ack !== 1'b0 || bif0.m0_rdata !== 32'hA5A5_5A4A) begin
      n_fail++;
      $display("FAIL wr_ack: got ack1=%b wr=%b ack0=%b m0_rdata=%h expected 1 0 0 a5a55a4a",
               bif0.m1_ack, bif0.MemWrite, bif0.m0_ack, bif0.m0_rdata);
    end
    bif0.m1_req = 1'b0;
    bif0.m1_we  = 1'b0;
    tick();
    @(negedge clk);
    n_tests++;
    if (bif0.m1_ack !== 1'b0 || bif0.MemWrite !== 1'b0) begin
      n_fail++;
      $display("FAIL wr_after: got ack1=%b wr=%b expected 0 0", bif0.m1_ack, bif0.MemWrite);
    end
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    reset   = 1'b1;
    bif0.m0_req = 1'b0; bif0.m0_we = 1'b0; bif0.m0_addr = '0; bif0.m0_wdata = '0;
    bif0.m1_req = 1'b0; bif0.m1_we = 1'b0; bif0.m1_addr = '0; bif0.m1_wdata = '0;
    bif1.m0_req = 1'b0; bif1.m0_we = 1'b0; bif1.m0_addr = '0; bif1.m0_wdata = '0;
    bif1.m1_req = 1'b0; bif1.m1_we = 1'b0; bif1.m1_addr = '0; bif1.m1_wdata = '0;

    test_reset();
    test_read();
    test_reset_mid();
    test_round_robin();
    test_fixed_prio();
    test_write();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
